// File: rtl/fp_addsub_seq_if.sv
// Handshake bundle for fp_addsub_seq: operand request channel and result channel.
// The master side supplies operands and accepts results; the slave side is the adder.
interface fp_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_inexact;
    logic         flag_invalid;
    logic         busy;

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, result,
        input  flag_overflow, flag_underflow, flag_inexact, flag_invalid, busy
    );

    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, result,
        output flag_overflow, flag_underflow, flag_inexact, flag_invalid, busy
    );
endinterface

// File: rtl/fp_addsub_if.sv
// The fp_addsub_seq handshake interface is declared in fp_addsub_seq_if.sv.
// This file carries no declarations of its own.

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-style floating-point adder/subtractor with flush-to-zero inputs,
// 1-bit/cycle alignment and normalisation, and round-to-nearest-even.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic           clk,
    input logic           rst,
    fp_addsub_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 5;
    localparam int EW = EXP_W + 1;
    localparam logic [EW-1:0] EXP_MAX   = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EW-1:0] ALIGN_CAP = EW'(MAN_W + 3);
    localparam logic [W-1:0]  QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    // Returns {carry, hidden, frac} after the RNE increment of {hidden, frac, G, R, S}.
    function automatic logic [MAN_W+1:0] round_rne(input logic [MAN_W+3:0] m);
        logic inc;
        inc = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc};
    endfunction

    function automatic logic [W-1:0] inf_word(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    result_q, result_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d, inv_q, inv_d;
    logic            in_ready_q, in_ready_d, busy_q, busy_d;

    logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [EW-1:0]   exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [M-1:0]    man_a_q, man_a_d, man_b_q, man_b_d;

    logic               a_s, b_s, a_inf, b_inf, a_zero, b_zero, swap;
    logic [EXP_W-1:0]   a_e, b_e;
    logic [MAN_W-1:0]   a_f, b_f;
    logic [MAN_W+1:0]   rnd;
    logic [EW-1:0]      exp_r;
    logic [MAN_W-1:0]   frac_r;

    assign a_s    = bus.a[W-1];
    assign a_e    = bus.a[W-2:MAN_W];
    assign a_f    = bus.a[MAN_W-1:0];
    assign b_s    = bus.b[W-1] ^ bus.op_sub;
    assign b_e    = bus.b[W-2:MAN_W];
    assign b_f    = bus.b[MAN_W-1:0];
    assign a_inf  = &a_e;
    assign b_inf  = &b_e;
    assign a_zero = ~|a_e;
    assign b_zero = ~|b_e;
    assign swap   = {b_e, b_f} > {a_e, a_f};

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        inv_d       = inv_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        man_a_d     = man_a_q;
        man_b_d     = man_b_q;
        rnd         = round_rne(man_a_q[M-2:0]);
        exp_r       = rnd[MAN_W+1] ? exp_a_q + EW'(1) : exp_a_q;
        frac_r      = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    inx_d = 1'b0;
                    inv_d = 1'b0;
                    if (a_inf || b_inf) begin
                        if (a_inf && b_inf && (a_s != b_s)) begin
                            result_d = QNAN;
                            inv_d    = 1'b1;
                        end else begin
                            result_d = inf_word(a_inf ? a_s : b_s);
                        end
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (a_zero || b_zero) begin
                        if (a_zero && b_zero) result_d = {a_s & b_s, {(W-1){1'b0}}};
                        else if (a_zero)      result_d = {b_s, b_e, b_f};
                        else                  result_d = bus.a;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        sign_a_d = swap ? b_s : a_s;
                        sign_b_d = swap ? a_s : b_s;
                        exp_a_d  = {1'b0, swap ? b_e : a_e};
                        exp_b_d  = {1'b0, swap ? a_e : b_e};
                        man_a_d  = {2'b01, swap ? b_f : a_f, 3'b000};
                        man_b_d  = {2'b01, swap ? a_f : b_f, 3'b000};
                        state_d  = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (exp_b_q == exp_a_q) begin
                    state_d = S_ADD;
                end else if ((exp_a_q - exp_b_q) > ALIGN_CAP) begin
                    // B lies entirely below the sticky position
                    man_b_d = {{(M-1){1'b0}}, |man_b_q};
                    exp_b_d = exp_a_q;
                end else begin
                    man_b_d = {1'b0, man_b_q[M-1:2], man_b_q[1] | man_b_q[0]};
                    exp_b_d = exp_b_q + EW'(1);
                end
            end
            S_ADD: begin
                man_a_d = (sign_a_q == sign_b_q) ? man_a_q + man_b_q : man_a_q - man_b_q;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (man_a_q[M-1]) begin
                    man_a_d = {1'b0, man_a_q[M-1:2], man_a_q[1] | man_a_q[0]};
                    exp_a_d = exp_a_q + EW'(1);
                    state_d = S_ROUND;
                end else if (man_a_q == '0) begin
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (!man_a_q[M-2]) begin
                    if (exp_a_q > EW'(1)) begin
                        man_a_d = {man_a_q[M-2:0], 1'b0};
                        exp_a_d = exp_a_q - EW'(1);
                    end else begin
                        result_d    = {sign_a_q, {(W-1){1'b0}}};
                        unf_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (exp_r >= EXP_MAX) begin
                    result_d = inf_word(sign_a_q);
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_a_q, exp_r[EXP_W-1:0], frac_r};
                    inx_d    = |man_a_q[2:0];
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Working operands are only meaningful once the controller has loaded them.
    always_ff @(posedge clk) begin
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
        exp_a_q  <= exp_a_d;
        exp_b_q  <= exp_b_d;
        man_a_q  <= man_a_d;
        man_b_q  <= man_b_d;
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.busy           = busy_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.result         = result_q;
    assign bus.flag_overflow  = ovf_q;
    assign bus.flag_underflow = unf_q;
    assign bus.flag_inexact   = inx_q;
    assign bus.flag_invalid   = inv_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq (single precision): results, flags,
// latency, output back-pressure and asynchronous reset mid-operation.
module tb_fp_addsub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_overflow, bus.flag_underflow, bus.flag_inexact, bus.flag_invalid};
    endfunction

    // Issue one operation and wait (bounded) for its result; hold_cycles keeps out_ready low.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sub, input logic [31:0] exp_res, input logic [3:0] exp_flg,
                          input int exp_lat, input int hold_cycles);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check_eq({tag, "_flags"}, 64'(flags()), 64'(exp_flg));
        if (exp_lat >= 0) check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (hold_cycles > 0) begin
            repeat (hold_cycles) @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_eq({tag, "_hold_result"}, 64'(bus.result), 64'(exp_res));
            check_eq({tag, "_hold_flags"}, 64'(flags()), 64'(exp_flg));
            check_eq({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            check_eq({tag, "_hold_busy"}, 64'(bus.busy), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "_released"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #3 rst = 1'b0;
        #10;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_flags", 64'(flags()), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // flags order: {overflow, underflow, inexact, invalid}
        run_op("add_carry",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4, 0);
        run_op("sub_zero",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, -1, 0);
        run_op("sub_norm24", 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000, 29, 0);
        run_op("collapse",   32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'b0010, 5, 0);
        run_op("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010, 28, 0);
        run_op("round_up",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0010, -1, 0);
        run_op("neg_diff",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, -1, 0);
        run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010, -1, 0);
        run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001, 0, 0);
        run_op("inf_pass",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 0, 0);
        run_op("zero_pass",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 0, 0);
        run_op("zero_zero",  32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 0, 0);
        run_op("underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0100, -1, 0);
        run_op("hold",       32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4, 10);

        // Asynchronous reset while B is still being aligned (24 shifts pending).
        @(negedge clk);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h33800000;
        bus.op_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_align_busy", 64'(bus.busy), 64'd1);
        #1 rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_busy", 64'(bus.busy), 64'd0);
        check_eq("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        run_op("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
